// File: rtl/minirisc_pkg.sv
// Shared MiniRISC constants and the fetch sequencer state encoding.
package minirisc_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_HOLD,
    S_HALTED
  } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC mux: redirect target beats sequential PC+4, which beats the saved resume PC.
module next_pc_sel
  import minirisc_pkg::*;
(
  input  logic            redirect_i,
  input  logic            use_seq_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic [XLEN-1:0] instr_pc_i,
  input  logic [XLEN-1:0] saved_pc_i,
  output logic [XLEN-1:0] next_pc_o
);

  always_comb begin
    next_pc_o = saved_pc_i;
    if (redirect_i) begin
      next_pc_o = redirect_pc_i & ~(XLEN'(INSTR_BYTES - 1));
    end else if (use_seq_i) begin
      // Modulo-2^32 wrap is intended; no carry out.
      next_pc_o = instr_pc_i + XLEN'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// MiniRISC instruction-fetch sequencer: owns the PC, talks req/ack to imem
// and valid/ready to decode, handles redirects and halt/resume.
module fetch_ctrl
  import minirisc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        halt,
  input  logic        resume,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  saved_pc_q, saved_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic [31:0]  next_pc;

  next_pc_sel u_next_pc_sel (
    .redirect_i    (redirect),
    .use_seq_i     (state_q == S_HOLD),
    .redirect_pc_i (redirect_pc),
    .instr_pc_i    (instr_pc_q),
    .saved_pc_i    (saved_pc_q),
    .next_pc_o     (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      saved_pc_q <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      saved_pc_q <= saved_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    saved_pc_d = saved_pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            fetch_pc_d = next_pc;
          end else begin
            state_d    = S_HOLD;
            instr_d    = imem_rdata;
            instr_pc_d = fetch_pc_q;
          end
        end else if (redirect) begin
          // Request cannot be withdrawn; finish it and park the target.
          state_d    = S_DRAIN;
          saved_pc_d = next_pc;
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          state_d    = S_FETCH;
          fetch_pc_d = next_pc;
        end else if (redirect) begin
          saved_pc_d = next_pc;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_d    = S_FETCH;
          fetch_pc_d = next_pc;
        end else if (instr_ready) begin
          if (halt) begin
            state_d    = S_HALTED;
            saved_pc_d = next_pc;
          end else begin
            state_d    = S_FETCH;
            fetch_pc_d = next_pc;
          end
        end
      end
      S_HALTED: begin
        if (resume) begin
          state_d    = S_FETCH;
          fetch_pc_d = next_pc;
        end else if (redirect) begin
          saved_pc_d = next_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs decode flops only, so no input reaches an output combinationally.
  assign imem_req    = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = (state_q == S_HOLD);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues expected fetch addresses and
// delivered PCs; a negedge monitor pops and compares as the DUT presents them.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        halt;
  logic        resume;
  logic        redirect;
  logic [31:0] redirect_pc;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned lat      = 0;
  int unsigned wcnt     = 0;
  bit          quiet    = 1'b0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halt        (halt),
    .resume      (resume),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0000_0100);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
  endtask

  task automatic wait_valid_pc(input logic [31:0] pc, input bit drop_ready);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (instr_valid && instr_pc == pc) found = 1'b1;
      else step();
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_valid_pc: instr_pc %h never presented, last %h", pc, instr_pc);
    end else if (drop_ready) begin
      instr_ready = 1'b0;
    end
  endtask

  // Memory model: ack after 'lat' wait cycles of a held request.
  initial begin : memory
    forever begin
      step();
      if (!rst_n || !imem_req) begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end else if (wcnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wcnt       = 0;
      end else begin
        imem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  initial begin : monitor
    logic [31:0] f;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_req) begin
          if (exp_addr_q.size() == 0) begin
            chk("unexpected_req", imem_addr, 32'hFFFF_FFFF);
          end else begin
            f = exp_addr_q[0];
            chk("imem_addr", imem_addr, f);
            if (imem_ack) void'(exp_addr_q.pop_front());
          end
        end
        if (instr_valid) chk("no_req_in_hold", {31'b0, imem_req}, 32'h0);
        if (instr_valid && instr_ready && !redirect) begin
          if (exp_pc_q.size() == 0) begin
            chk("unexpected_instr", instr_pc, 32'hFFFF_FFFF);
          end else begin
            f = exp_pc_q.pop_front();
            chk("instr_pc", instr_pc, f);
            chk("instr", instr, mem_word(f));
          end
        end
        if (quiet) begin
          chk("halted_req", {31'b0, imem_req}, 32'h0);
          chk("halted_valid", {31'b0, instr_valid}, 32'h0);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] pc_tab [3];
    pc_tab = '{32'h100, 32'h104, 32'h108};
    rst_n = 1'b0; instr_ready = 1'b1; halt = 1'b0; resume = 1'b0;
    redirect = 1'b0; redirect_pc = '0; lat = 0;
    step(); step();
    chk_reset_outputs();

    // Sequential fetch at zero wait: request and valid alternate.
    exp_addr_q.push_back(32'h100); exp_addr_q.push_back(32'h104);
    exp_addr_q.push_back(32'h108);
    exp_pc_q.push_back(32'h100); exp_pc_q.push_back(32'h104);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("seq_req", {31'b0, imem_req}, {31'b0, (k % 2) == 1});
      chk("seq_valid", {31'b0, instr_valid}, {31'b0, (k % 2) == 0});
      if (k % 2 == 1) chk("seq_addr", imem_addr, pc_tab[(k - 1) / 2]);
      else chk("seq_instr_pc", instr_pc, pc_tab[k / 2 - 1]);
    end
    instr_ready = 1'b0;

    // Squash 0x108, fetch 0x10 with latency 3, redirect to 0x203 while pending.
    lat = 3;
    exp_addr_q.push_back(32'h10);
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    step();
    exp_addr_q.push_back(32'h200);
    redirect = 1'b1; redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    chk("drain_req", {31'b0, imem_req}, 32'h1);
    chk("drain_addr", imem_addr, 32'h10);
    wait_valid_pc(32'h200, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("hold_instr", instr, mem_word(32'h200));
      chk("hold_valid", {31'b0, instr_valid}, 32'h1);
      step();
    end
    exp_pc_q.push_back(32'h200);
    exp_addr_q.push_back(32'h204);
    instr_ready = 1'b1;
    wait_valid_pc(32'h204, 1'b1);

    // Redirect in HOLD without ready squashes 0x204.
    lat = 0;
    exp_addr_q.push_back(32'h400);
    redirect = 1'b1; redirect_pc = 32'h400;
    step();
    redirect = 1'b0;
    wait_valid_pc(32'h400, 1'b0);
    chk("redir_instr", instr, mem_word(32'h400));

    // HALT accepted at 0x3C, resume 10 cycles later at 0x40.
    exp_addr_q.push_back(32'h38); exp_addr_q.push_back(32'h3C);
    exp_pc_q.push_back(32'h38); exp_pc_q.push_back(32'h3C);
    redirect = 1'b1; redirect_pc = 32'h38; instr_ready = 1'b1;
    step();
    redirect = 1'b0;
    wait_valid_pc(32'h3C, 1'b0);
    halt = 1'b1;
    step();
    halt = 1'b0; instr_ready = 1'b0; quiet = 1'b1;
    repeat (10) step();
    quiet = 1'b0;
    exp_addr_q.push_back(32'h40);
    resume = 1'b1;
    step();
    resume = 1'b0;
    wait_valid_pc(32'h40, 1'b0);

    // PC+4 wraps from 0xFFFF_FFFC to 0.
    exp_addr_q.push_back(32'hFFFF_FFFC); exp_addr_q.push_back(32'h0);
    exp_pc_q.push_back(32'hFFFF_FFFC);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; instr_ready = 1'b1;
    step();
    redirect = 1'b0;
    wait_valid_pc(32'h0, 1'b1);
    chk("wrap_instr", instr, mem_word(32'h0));

    // Reset asserted while draining; refetch from RESET_PC.
    lat = 5;
    exp_addr_q.push_back(32'h500);
    redirect = 1'b1; redirect_pc = 32'h500;
    step();
    redirect = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h600;
    step();
    redirect = 1'b0;
    chk("pre_rst_req", {31'b0, imem_req}, 32'h1);
    chk("pre_rst_addr", imem_addr, 32'h500);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    exp_addr_q.delete();
    exp_pc_q.delete();
    lat = 0;
    exp_addr_q.push_back(32'h100); exp_addr_q.push_back(32'h104);
    step(); step();
    rst_n = 1'b1;
    wait_valid_pc(32'h100, 1'b0);
    chk("refetch_instr", instr, mem_word(32'h100));
    exp_pc_q.push_back(32'h100);
    instr_ready = 1'b1;
    step();
    wait_valid_pc(32'h104, 1'b1);
    repeat (3) step();
    chk("addr_queue_drained", exp_addr_q.size(), 32'h0);
    chk("instr_queue_drained", exp_pc_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
